// File: rtl/bkm_step_scoreboard.sv
// ---------------------------------------------------------------------------
// bkm_step_scoreboard
//
// Purpose:
//   In-order scoreboard for a bkm_step datapath. Expected {X, Y} pairs are
//   queued in a small FIFO. Each monitor result pops the oldest pair and
//   compares it bit-exactly. The comparison outcome is registered, so it
//   appears as a one-cycle pass or fail pulse in the cycle after the pop.
//   Optionally, checking halts after the first mismatch.
//
// Ports:
//   clk                    single clock, all logic on the rising edge
//   srst                   synchronous active-high reset
//   enable                 qualifies every push, pop and state update
//   exp_valid              an expected pair is present on exp_X/Y_np1
//   exp_X_np1, exp_Y_np1   expected X / Y words (WD bits each)
//   exp_ready              FIFO not full
//   res_valid              a monitor result is present on res_X/Y_np1
//   res_X_np1, res_Y_np1   observed X / Y words (WD bits each)
//   pass, fail             one-cycle comparison result pulses
//   mism_X, mism_Y         per-component mismatch, valid together with fail
//   chk_cnt, err_cnt       saturating comparison and mismatch counters
//   overflow, underflow    sticky: push while full / result while empty
//   halted                 checking stopped after a mismatch
//   level                  FIFO occupancy, 0..DEPTH
// ---------------------------------------------------------------------------
module bkm_step_scoreboard #(
   parameter int WD          = 64,
   parameter int DEPTH       = 8,
   parameter int STOP_ON_ERR = 0
) (
   input  logic                       clk,
   input  logic                       srst,
   input  logic                       enable,
   input  logic                       exp_valid,
   input  logic [WD-1:0]              exp_X_np1,
   input  logic [WD-1:0]              exp_Y_np1,
   output logic                       exp_ready,
   input  logic                       res_valid,
   input  logic [WD-1:0]              res_X_np1,
   input  logic [WD-1:0]              res_Y_np1,
   output logic                       pass,
   output logic                       fail,
   output logic                       mism_X,
   output logic                       mism_Y,
   output logic [15:0]                chk_cnt,
   output logic [15:0]                err_cnt,
   output logic                       overflow,
   output logic                       underflow,
   output logic                       halted,
   output logic [$clog2(DEPTH):0]     level
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   typedef enum logic {
      RUN  = 1'b0,
      HALT = 1'b1
   } state_t;

   state_t          r_state;
   state_t          w_state_nxt;

   logic [WD-1:0]   r_mem_x [DEPTH];
   logic [WD-1:0]   r_mem_y [DEPTH];
   logic [AW-1:0]   r_wr_ptr;
   logic [AW-1:0]   r_rd_ptr;
   logic [LW-1:0]   r_level;
   logic [15:0]     r_chk_cnt;
   logic [15:0]     r_err_cnt;
   logic            r_pass;
   logic            r_fail;
   logic            r_mism_x;
   logic            r_mism_y;
   logic            r_overflow;
   logic            r_underflow;

   logic            w_full;
   logic            w_empty;
   logic            w_run;
   logic            w_pop;
   logic            w_push;
   logic            w_mism_x;
   logic            w_mism_y;
   logic            w_mism;

   assign w_full  = (r_level == LW'(DEPTH));
   assign w_empty = (r_level == '0);
   assign w_run   = (r_state == RUN);

   // The pop is evaluated first so that a push into a full FIFO is still
   // accepted when a pop frees a slot in the same cycle. A push into an
   // empty FIFO is never compared in the same cycle: pop requires !empty.
   assign w_pop  = enable & res_valid & ~w_empty & w_run;
   assign w_push = enable & exp_valid & (~w_full | w_pop);

   assign w_mism_x = (r_mem_x[r_rd_ptr] != res_X_np1);
   assign w_mism_y = (r_mem_y[r_rd_ptr] != res_Y_np1);
   assign w_mism   = w_mism_x | w_mism_y;

   // ---------------------------------------------------------------------
   // FSM next state: RUN falls into HALT on a mismatching pop when halting
   // is enabled; only srst leaves HALT.
   // ---------------------------------------------------------------------
   always_comb begin
      // NOTE: default assigned first so no path leaves w_state_nxt unassigned (no latch).
      w_state_nxt = r_state;
      case (r_state)
         RUN:     if ((STOP_ON_ERR != 0) && w_pop && w_mism) w_state_nxt = HALT;
         HALT:    w_state_nxt = HALT;
         default: w_state_nxt = RUN;
      endcase
   end

   // ---------------------------------------------------------------------
   // FIFO storage
   // ---------------------------------------------------------------------
   // NOTE: storage has no reset; pointers and level alone define validity.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem_x[r_wr_ptr] <= exp_X_np1;
         r_mem_y[r_wr_ptr] <= exp_Y_np1;
      end
   end

   // ---------------------------------------------------------------------
   // Control state, counters, registered comparison and sticky flags
   // ---------------------------------------------------------------------
   // NOTE: non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (srst) begin
         r_state     <= RUN;
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
         r_level     <= '0;
         r_chk_cnt   <= '0;
         r_err_cnt   <= '0;
         r_pass      <= 1'b0;
         r_fail      <= 1'b0;
         r_mism_x    <= 1'b0;
         r_mism_y    <= 1'b0;
         r_overflow  <= 1'b0;
         r_underflow <= 1'b0;
      end else begin
         r_state <= w_state_nxt;

         // The pulses are rebuilt every cycle, so they drop after one
         // cycle even while enable is low (w_pop is already qualified).
         r_pass   <= w_pop & ~w_mism;
         r_fail   <= w_pop &  w_mism;
         r_mism_x <= w_pop &  w_mism_x;
         r_mism_y <= w_pop &  w_mism_y;

         if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);

         case ({w_push, w_pop})
            2'b10:   r_level <= r_level + LW'(1);
            2'b01:   r_level <= r_level - LW'(1);
            default: r_level <= r_level;
         endcase

         if (w_pop && (r_chk_cnt != 16'hFFFF))
            r_chk_cnt <= r_chk_cnt + 16'd1;
         if (w_pop && w_mism && (r_err_cnt != 16'hFFFF))
            r_err_cnt <= r_err_cnt + 16'd1;

         if (enable & exp_valid & w_full & ~w_pop)
            r_overflow <= 1'b1;
         if (enable & res_valid & w_empty & w_run)
            r_underflow <= 1'b1;
      end
   end

   assign exp_ready = ~w_full;
   assign pass      = r_pass;
   assign fail      = r_fail;
   assign mism_X    = r_mism_x;
   assign mism_Y    = r_mism_y;
   assign chk_cnt   = r_chk_cnt;
   assign err_cnt   = r_err_cnt;
   assign overflow  = r_overflow;
   assign underflow = r_underflow;
   assign halted    = (r_state == HALT);
   assign level     = r_level;

endmodule

// File: tb/tb_bkm_step_scoreboard.sv
// ---------------------------------------------------------------------------
// tb_bkm_step_scoreboard
//
// Purpose:
//   Self-checking bench for bkm_step_scoreboard (WD=64, DEPTH=8,
//   STOP_ON_ERR=1). It runs directed scenarios followed by a randomized
//   phase. Expected outputs come from a queue-based reference model: one
//   call of step() is one clock cycle. step() drives the inputs, advances
//   the model, waits for the edge and compares every output 1 time unit
//   later.
// ---------------------------------------------------------------------------
module tb_bkm_step_scoreboard;

   localparam int WD    = 64;
   localparam int DEPTH = 8;

   logic          clk = 1'b0;
   logic          srst;
   logic          enable;
   logic          exp_valid;
   logic [WD-1:0] exp_X_np1;
   logic [WD-1:0] exp_Y_np1;
   logic          exp_ready;
   logic          res_valid;
   logic [WD-1:0] res_X_np1;
   logic [WD-1:0] res_Y_np1;
   logic          pass;
   logic          fail;
   logic          mism_X;
   logic          mism_Y;
   logic [15:0]   chk_cnt;
   logic [15:0]   err_cnt;
   logic          overflow;
   logic          underflow;
   logic          halted;
   logic [3:0]    level;

   always #5 clk = ~clk;

   bkm_step_scoreboard #(
      .WD          (WD),
      .DEPTH       (DEPTH),
      .STOP_ON_ERR (1)
   ) dut (
      .clk       (clk),
      .srst      (srst),
      .enable    (enable),
      .exp_valid (exp_valid),
      .exp_X_np1 (exp_X_np1),
      .exp_Y_np1 (exp_Y_np1),
      .exp_ready (exp_ready),
      .res_valid (res_valid),
      .res_X_np1 (res_X_np1),
      .res_Y_np1 (res_Y_np1),
      .pass      (pass),
      .fail      (fail),
      .mism_X    (mism_X),
      .mism_Y    (mism_Y),
      .chk_cnt   (chk_cnt),
      .err_cnt   (err_cnt),
      .overflow  (overflow),
      .underflow (underflow),
      .halted    (halted),
      .level     (level)
   );

   // ---------------------------------------------------------------------
   // Reference model: an ordered queue of expected pairs plus flags
   // ---------------------------------------------------------------------
   typedef struct {
      logic [WD-1:0] x;
      logic [WD-1:0] y;
   } pair_t;

   pair_t       m_q[$];
   int unsigned m_chk, m_err;
   bit          m_pass, m_fail, m_mx, m_my, m_ovf, m_udf, m_halt;

   int n_run  = 0;
   int n_fail = 0;

   task automatic chk(input string tag, input logic [WD-1:0] obs, input logic [WD-1:0] exp);
      n_run++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model(input bit rs, en, ev, input logic [WD-1:0] ex, ey,
                        input bit rv, input logic [WD-1:0] rx, ry);
      bit    do_pop, do_push;
      pair_t p;
      if (rs) begin
         m_q.delete();
         m_chk = 0; m_err = 0;
         {m_pass, m_fail, m_mx, m_my, m_ovf, m_udf, m_halt} = '0;
         return;
      end
      do_pop  = en && rv && (m_q.size() > 0) && !m_halt;
      do_push = en && ev && ((m_q.size() < DEPTH) || do_pop);
      if (en && ev && !do_push) m_ovf = 1'b1;
      if (en && rv && (m_q.size() == 0) && !m_halt) m_udf = 1'b1;
      {m_pass, m_fail, m_mx, m_my} = '0;
      if (do_pop) begin
         p      = m_q.pop_front();
         m_mx   = (p.x != rx);
         m_my   = (p.y != ry);
         m_fail = m_mx || m_my;
         m_pass = !m_fail;
         if (m_chk < 16'hFFFF) m_chk++;
         if (m_fail && m_err < 16'hFFFF) m_err++;
         if (m_fail) m_halt = 1'b1;
      end
      if (do_push) begin
         p.x = ex;
         p.y = ey;
         m_q.push_back(p);
      end
   endtask

   task automatic check_all();
      chk("level",     WD'(level),     WD'(m_q.size()));
      chk("exp_ready", WD'(exp_ready), WD'(m_q.size() < DEPTH));
      chk("pass",      WD'(pass),      WD'(m_pass));
      chk("fail",      WD'(fail),      WD'(m_fail));
      chk("mism_X",    WD'(mism_X),    WD'(m_mx));
      chk("mism_Y",    WD'(mism_Y),    WD'(m_my));
      chk("chk_cnt",   WD'(chk_cnt),   WD'(m_chk));
      chk("err_cnt",   WD'(err_cnt),   WD'(m_err));
      chk("overflow",  WD'(overflow),  WD'(m_ovf));
      chk("underflow", WD'(underflow), WD'(m_udf));
      chk("halted",    WD'(halted),    WD'(m_halt));
   endtask

   // One clock cycle: drive inputs, advance the model, compare after the edge.
   task automatic step(input bit rs, en, ev, input logic [WD-1:0] ex, ey,
                       input bit rv, input logic [WD-1:0] rx, ry);
      srst = rs; enable = en; exp_valid = ev; exp_X_np1 = ex; exp_Y_np1 = ey;
      res_valid = rv; res_X_np1 = rx; res_Y_np1 = ry;
      model(rs, en, ev, ex, ey, rv, rx, ry);
      @(posedge clk);
      #1;
      check_all();
   endtask

   task automatic do_reset();
      step(1, 0, 0, '0, '0, 0, '0, '0);
   endtask

   task automatic push(input logic [WD-1:0] x, y);
      step(0, 1, 1, x, y, 0, '0, '0);
   endtask

   task automatic result(input logic [WD-1:0] x, y);
      step(0, 1, 0, '0, '0, 1, x, y);
   endtask

   initial begin
      logic [WD-1:0] rx, ry;
      bit            en, ev, rv, rs;

      // Reset state
      do_reset();
      chk("rst_level", WD'(level), 64'd0);
      chk("rst_ready", WD'(exp_ready), 64'd1);

      // Three matching pairs: each pass shows the cycle after its pop
      for (int i = 1; i <= 3; i++) push(64'(i * 16), 64'(i * 16 + 1));
      for (int i = 1; i <= 3; i++) begin
         result(64'(i * 16), 64'(i * 16 + 1));
         chk("pass_pulse", WD'(pass), 64'd1);
      end
      step(0, 1, 0, '0, '0, 0, '0, '0);
      chk("pass_drop", WD'(pass), 64'd0);
      chk("chk3", WD'(chk_cnt), 64'd3);
      chk("err0", WD'(err_cnt), 64'd0);
      chk("lvl0", WD'(level), 64'd0);

      // Result with an empty FIFO, then result plus same-cycle push
      result(64'h1, 64'h2);
      chk("udf_set", WD'(underflow), 64'd1);
      chk("udf_chk", WD'(chk_cnt), 64'd3);
      step(0, 1, 1, 64'h77, 64'h78, 1, 64'h77, 64'h78);
      chk("bypass_lvl", WD'(level), 64'd1);
      chk("bypass_pass", WD'(pass), 64'd0);
      result(64'h77, 64'h78);
      do_reset();

      // Fill to DEPTH, push+pop at full, then a lone push overflows
      for (int i = 0; i < DEPTH; i++) push(64'(i + 200), 64'(i + 300));
      chk("full_ready", WD'(exp_ready), 64'd0);
      chk("full_lvl", WD'(level), 64'd8);
      step(0, 1, 1, 64'd208, 64'd308, 1, 64'd200, 64'd300);
      chk("fullpp_lvl", WD'(level), 64'd8);
      chk("fullpp_ovf", WD'(overflow), 64'd0);
      push(64'd999, 64'd999);
      chk("ovf_set", WD'(overflow), 64'd1);
      chk("ovf_lvl", WD'(level), 64'd8);
      for (int i = 1; i <= DEPTH; i++) result(64'(i + 200), 64'(i + 300));
      do_reset();

      // Interleaved push/pop of 0..11 wraps both pointers
      push(64'd0, 64'd100);
      for (int i = 1; i < 12; i++) begin
         step(0, 1, 1, 64'(i), 64'(i + 100), 1, 64'(i - 1), 64'(i + 99));
         chk("wrap_pass", WD'(pass), 64'd1);
      end
      result(64'd11, 64'd111);
      chk("wrap_chk", WD'(chk_cnt), 64'd12);
      chk("wrap_err", WD'(err_cnt), 64'd0);

      // srst during a pop at level 4 discards the in-flight comparison
      for (int i = 0; i < 4; i++) push(64'(i), 64'(i));
      step(1, 1, 1, 64'h5, 64'h5, 1, 64'd0, 64'd0);
      chk("srst_lvl", WD'(level), 64'd0);
      chk("srst_cnt", WD'(chk_cnt), 64'd0);
      chk("srst_pass", WD'(pass), 64'd0);
      step(0, 0, 0, '0, '0, 0, '0, '0);
      chk("srst_pass2", WD'(pass), 64'd0);

      // enable low holds everything while the previous pulse still drops
      push(64'hA, 64'hB);
      push(64'hC, 64'hD);
      result(64'hA, 64'hB);
      for (int i = 0; i < 5; i++) step(0, 0, 1, 64'hE, 64'hF, 1, 64'hC, 64'hD);
      chk("hold_lvl", WD'(level), 64'd1);
      chk("hold_chk", WD'(chk_cnt), 64'd1);
      chk("hold_pass", WD'(pass), 64'd0);
      result(64'hC, 64'hD);
      do_reset();

      // Y-only mismatch halts checking
      push(64'h55, 64'hAA);
      result(64'h55, 64'hAB);
      chk("mm_fail", WD'(fail), 64'd1);
      chk("mm_x", WD'(mism_X), 64'd0);
      chk("mm_y", WD'(mism_Y), 64'd1);
      chk("mm_err", WD'(err_cnt), 64'd1);
      chk("mm_halt", WD'(halted), 64'd1);
      push(64'h66, 64'h67);
      result(64'h66, 64'h67);
      result(64'h66, 64'h67);
      chk("halt_chk", WD'(chk_cnt), 64'd1);
      chk("halt_lvl", WD'(level), 64'd1);
      chk("halt_udf", WD'(underflow), 64'd0);
      do_reset();

      // Randomized traffic against the model
      for (int c = 0; c < 400; c++) begin
         rs = m_halt ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 99) == 0);
         en = ($urandom_range(0, 7) != 0);
         ev = $urandom_range(0, 1) == 1;
         rv = $urandom_range(0, 2) == 0;
         if (m_q.size() > 0) begin
            rx = m_q[0].x;
            ry = m_q[0].y;
            if ($urandom_range(0, 24) == 0) rx[$urandom_range(0, WD - 1)] ^= 1'b1;
            if ($urandom_range(0, 24) == 0) ry[$urandom_range(0, WD - 1)] ^= 1'b1;
         end else begin
            rx = {$urandom, $urandom};
            ry = {$urandom, $urandom};
         end
         step(rs, en, ev, {$urandom, $urandom}, {$urandom, $urandom}, rv, rx, ry);
      end

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
